// File: rtl/genius_seq_gen.sv
// ============================================================================
// Module   : genius_seq_gen
// Purpose  : Genius game pattern generator. Appends one symbol per round and
//            serves registered indexed reads of the stored sequence.
// Option   : GENIUS_FIXED_SEQ_EN selects a fixed 16-entry demo table as the
//            symbol source instead of the free-running LFSR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module genius_seq_gen #(
    parameter int          SYM_W   = 2,
    parameter int          NUM_SYM = 3,
    parameter int          DEPTH   = 16,
    parameter int          IDX_W   = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             append,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [SYM_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_oob,
    output logic [IDX_W:0]   length,
    output logic             busy,
    output logic             full,
    output logic             overflow
);

    // Truncation to SYM_W gives 0 when NUM_SYM == 2**SYM_W, which still folds correctly.
    localparam logic [SYM_W-1:0] c_num_sym = SYM_W'(NUM_SYM);
    localparam logic [IDX_W:0]   c_depth   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   c_len_one = (IDX_W+1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clear;
    logic               w_commit;
    logic               w_set_ovf;

    logic [15:0]        r_lfsr;
    logic [IDX_W:0]     r_length;
    logic               r_overflow;
    logic [SYM_W-1:0]   r_mem [DEPTH];
    logic [SYM_W-1:0]   r_rd_data;
    logic               r_rd_valid;
    logic               r_rd_oob;

    logic [SYM_W-1:0]   w_raw;
    logic [SYM_W-1:0]   w_sym;
    logic               w_full;
    logic               w_rd_oob;

    // ------------------------------------------------------------------
    // Free-running LFSR; phase depends on when the player acts
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // ------------------------------------------------------------------
    // Symbol source
    // ------------------------------------------------------------------
`ifdef GENIUS_FIXED_SEQ_EN
    logic [3:0] w_tbl_idx;
    logic [1:0] w_tbl_val;

    assign w_tbl_idx = 4'(r_length);

    always_comb begin
        w_tbl_val = 2'd0;
        case (w_tbl_idx)
            4'd0:    w_tbl_val = 2'd2;
            4'd1:    w_tbl_val = 2'd1;
            4'd2:    w_tbl_val = 2'd0;
            4'd3:    w_tbl_val = 2'd1;
            4'd4:    w_tbl_val = 2'd0;
            4'd5:    w_tbl_val = 2'd2;
            4'd6:    w_tbl_val = 2'd0;
            4'd7:    w_tbl_val = 2'd2;
            4'd8:    w_tbl_val = 2'd0;
            4'd9:    w_tbl_val = 2'd1;
            4'd10:   w_tbl_val = 2'd0;
            4'd11:   w_tbl_val = 2'd2;
            4'd12:   w_tbl_val = 2'd0;
            4'd13:   w_tbl_val = 2'd1;
            4'd14:   w_tbl_val = 2'd0;
            4'd15:   w_tbl_val = 2'd1;
            default: w_tbl_val = 2'd0;
        endcase
    end

    assign w_raw = SYM_W'(w_tbl_val);
`else
    assign w_raw = r_lfsr[SYM_W-1:0];
`endif

    // 2**SYM_W <= 2*NUM_SYM, so a single subtraction always lands in range
    assign w_sym = (w_raw >= c_num_sym) ? (w_raw - c_num_sym) : w_raw;

    assign w_full = (r_length == c_depth);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
        w_set_ovf   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_GEN;
                end else if (append) begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_state_nxt = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                // A restart drops the pending write and generates symbol 0 again
                if (start) begin
                    w_clear = 1'b1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_length   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clear) begin
                r_length <= '0;
            end else if (w_commit) begin
                r_length <= r_length + c_len_one;
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not cleared; length alone defines which entries are valid
    always_ff @(posedge clk) begin
        if (w_commit && !reset) begin
            r_mem[r_length[IDX_W-1:0]] <= w_sym;
        end
    end

    // ------------------------------------------------------------------
    // Read port (no bypass of a write in flight)
    // ------------------------------------------------------------------
    assign w_rd_oob = ({1'b0, rd_idx} >= r_length);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_oob   <= rd_en && w_rd_oob;
            if (rd_en) begin
                r_rd_data <= w_rd_oob ? '0 : r_mem[rd_idx];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_oob   = r_rd_oob;
    assign length   = r_length;
    assign busy     = (r_state == ST_GEN);
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_genius_seq_gen.sv
// ============================================================================
// Module   : tb_genius_seq_gen
// Purpose  : Self-checking bench for genius_seq_gen (directed table, corner
//            sequences and randomized traffic against a sequence-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genius_seq_gen;

    localparam int          SYM_W   = 2;
    localparam int          NUM_SYM = 3;
    localparam int          DEPTH   = 16;
    localparam int          IDX_W   = 4;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             append;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [SYM_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_oob;
    logic [IDX_W:0]   length;
    logic             busy;
    logic             full;
    logic             overflow;

    genius_seq_gen #(
        .SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .DEPTH(DEPTH), .IDX_W(IDX_W), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .append(append),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_oob(rd_oob), .length(length), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sequence-level reference: the stored game sequence plus a pending-generate flag
    int          q[$];
    bit          m_gen;
    bit          m_ovf;
    logic [15:0] m_lfsr;
    bit          e_valid;
    bit          e_oob;
    int          e_data;
    int          hist[NUM_SYM];
    int          fixed_tbl[16] = '{2,1,0,1,0,2,0,2,0,1,0,2,0,1,0,1};

    typedef struct {
        bit st; bit ap; bit re; int idx;
        int len; bit bsy; bit vld; bit oob;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int sym_of(input logic [15:0] l, input int len);
        int s;
`ifdef GENIUS_FIXED_SEQ_EN
        s = fixed_tbl[len % 16];
`else
        s = int'(l) % (1 << SYM_W);
`endif
        if (s >= NUM_SYM) s = s - NUM_SYM;
        return s;
    endfunction

    // Apply one cycle of inputs, advance the model, then check all outputs
    task automatic step(input bit rst, input bit st, input bit ap, input bit re, input int idx);
        reset  = rst;
        start  = st;
        append = ap;
        rd_en  = re;
        rd_idx = IDX_W'(idx);
        if (rst) begin
            e_valid = 0; e_oob = 0; e_data = 0;
            q.delete(); m_gen = 0; m_ovf = 0; m_lfsr = SEED;
        end else begin
            e_valid = re; e_oob = 0; e_data = 0;
            if (re) begin
                if (idx < q.size()) e_data = q[idx];
                else e_oob = 1;
            end
            if (m_gen) begin
                if (st) q.delete();
                else begin
                    q.push_back(sym_of(m_lfsr, q.size()));
                    m_gen = 0;
                end
            end else if (st) begin
                q.delete(); m_ovf = 0; m_gen = 1;
            end else if (ap) begin
                if (q.size() == DEPTH) m_ovf = 1;
                else m_gen = 1;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        @(posedge clk);
        #1;
        chk("length",   int'(length),   q.size());
        chk("busy",     int'(busy),     int'(m_gen));
        chk("full",     int'(full),     int'(q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("rd_valid", int'(rd_valid), int'(e_valid));
        chk("lfsr",     int'(dut.r_lfsr), int'(m_lfsr));
        if (e_valid) begin
            chk("rd_oob",  int'(rd_oob),  int'(e_oob));
            chk("rd_data", int'(rd_data), e_data);
            if (rd_valid && !rd_oob && int'(rd_data) < NUM_SYM) hist[int'(rd_data)]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; append = 0; rd_en = 0; rd_idx = '0;
        for (int i = 0; i < NUM_SYM; i++) hist[i] = 0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("seed", int'(dut.r_lfsr), int'(SEED));
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_oob", int'(rd_oob), 0);
        idle(5);

        // Directed table: start+append together, restart while busy, reads at the edges
        vecs[0]  = '{1,1,0,0, 0,1,0,0};
        vecs[1]  = '{0,0,0,0, 1,0,0,0};
        vecs[2]  = '{0,1,0,0, 1,1,0,0};
        vecs[3]  = '{1,0,0,0, 0,1,0,0};
        vecs[4]  = '{0,0,0,0, 1,0,0,0};
        vecs[5]  = '{0,1,0,0, 1,1,0,0};
        vecs[6]  = '{0,0,0,0, 2,0,0,0};
        vecs[7]  = '{0,1,0,0, 2,1,0,0};
        vecs[8]  = '{0,0,0,0, 3,0,0,0};
        vecs[9]  = '{0,0,1,5, 3,0,1,1};
        vecs[10] = '{0,0,1,2, 3,0,1,0};
        vecs[11] = '{0,0,0,0, 3,0,0,0};
        vecs[12] = '{0,1,1,2, 3,1,1,0};
        vecs[13] = '{0,0,1,3, 4,0,1,1};
        vecs[14] = '{0,0,1,3, 4,0,1,0};
        for (int i = 0; i < 15; i++) begin
            step(0, vecs[i].st, vecs[i].ap, vecs[i].re, vecs[i].idx);
            chk($sformatf("vec%0d_len", i), int'(length), vecs[i].len);
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
            chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_oob", i), int'(rd_oob), int'(vecs[i].oob));
                if (vecs[i].oob) chk($sformatf("vec%0d_oob_data", i), int'(rd_data), 0);
            end
        end

        // Fill to DEPTH, read back, overflow, then restart
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(2);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, 0, 1, 0, 0);
            idle(2);
        end
        chk("fill_len", int'(length), DEPTH);
        chk("fill_full", int'(full), 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 1, i);
`ifdef GENIUS_FIXED_SEQ_EN
            chk($sformatf("fixed_rd%0d", i), int'(rd_data), fixed_tbl[i]);
`endif
        end
        step(0, 0, 1, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_len", int'(length), DEPTH);
        idle(1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("restart_len", int'(length), 1);
        chk("restart_ovf", int'(overflow), 0);

        // Reset while a write is in flight
        step(0, 0, 1, 0, 0);
        chk("midgen_busy", int'(busy), 1);
        step(1, 0, 0, 0, 0);
        chk("midgen_len", int'(length), 0);
        chk("midgen_busy_clr", int'(busy), 0);
        idle(1);

        // Randomized traffic
        for (int run = 0; run < 200; run++) begin
            int ncyc;
            step(0, 1, 0, 0, 0);
            ncyc = $urandom_range(10, 30);
            for (int c = 0; c < ncyc; c++) begin
                step($urandom_range(0, 99) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, DEPTH - 1));
                if (rd_valid && !rd_oob) begin
                    n_tests++;
                    if (int'(rd_data) >= NUM_SYM) begin
                        n_fail++;
                        $display("FAIL sym_range: got %0d, expected < %0d", rd_data, NUM_SYM);
                    end
                end
            end
            for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i);
        end
        for (int i = 0; i < NUM_SYM; i++) chk($sformatf("sym%0d_seen", i), int'(hist[i] > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
